// File: rtl/adler32_pkg.sv
// Shared definitions for the Adler-32 job scheduler: FSM states and checksum constants.
package adler32_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_STREAM,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int unsigned ADLER_MOD    = 65521;
  localparam logic [31:0] ADLER_INIT   = 32'h0000_0001;
  localparam int unsigned WAIT_MAX_DEF = 8;

endpackage

// File: rtl/adler32_rr_arb.sv
// Two-way round-robin picker: with both requesters asking, the one not served last wins.
module adler32_rr_arb
  import adler32_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  // combinational one-hot pick; the last-served pointer lives in the parent
  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/adler32_sched.sv
// Schedules checksum jobs from two requesters onto one shared Adler-32 engine.
module adler32_sched
  import adler32_pkg::*;
#(
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [63:0] req_size,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_data_valid,
  output logic [1:0]  gnt,
  output logic [1:0]  data_ready,
  output logic [1:0]  done,
  output logic        resp_err,
  output logic [31:0] resp_checksum,
  output logic        eng_size_valid,
  output logic [31:0] eng_size,
  output logic        eng_data_start,
  output logic [7:0]  eng_data,
  input  logic        eng_checksum_valid,
  input  logic [31:0] eng_checksum
);

  state_t      state;
  state_t      state_nxt;
  logic        owner;
  logic        last;
  logic [31:0] size_q;
  logic [31:0] remaining;
  logic [31:0] wait_cnt;
  logic        err_q;
  logic [1:0]  pick;
  logic [1:0]  own_oh;
  logic [7:0]  own_byte;
  logic        own_valid;
  logic [31:0] pick_size;
  logic        wait_expired;

  adler32_rr_arb u_arb (
    .req  (req),
    .last (last),
    .pick (pick)
  );

  assign own_oh       = owner ? 2'b10 : 2'b01;
  assign own_byte     = owner ? req_data[15:8] : req_data[7:0];
  assign own_valid    = req_data_valid[owner];
  assign pick_size    = pick[1] ? req_size[63:32] : req_size[31:0];
  assign wait_expired = (wait_cnt == WAIT_MAX - 1);

  // state register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and all handshake/engine outputs, decoded from the current state
  always_comb begin
    state_nxt      = state;
    gnt            = 2'b00;
    data_ready     = 2'b00;
    done           = 2'b00;
    resp_err       = 1'b0;
    eng_size_valid = 1'b0;
    eng_size       = 32'd0;
    eng_data_start = 1'b0;
    eng_data       = 8'd0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nxt = (pick_size == 32'd0) ? ST_RESP : ST_LOAD;
        end
      end
      ST_LOAD: begin
        gnt            = own_oh;
        eng_size_valid = 1'b1;
        eng_size       = size_q;
        state_nxt      = ST_START;
      end
      ST_START: begin
        gnt            = own_oh;
        eng_data_start = 1'b1;
        state_nxt      = ST_STREAM;
      end
      ST_STREAM: begin
        gnt        = own_oh;
        data_ready = own_oh;
        if (own_valid) begin
          eng_data = own_byte;
          if (remaining == 32'd1) begin
            state_nxt = ST_WAIT;
          end
        end else begin
          // a starved stream is abandoned at once; the engine sees a zero byte
          state_nxt = ST_RESP;
        end
      end
      ST_WAIT: begin
        gnt = own_oh;
        if (eng_checksum_valid || wait_expired) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        gnt       = own_oh;
        done      = own_oh;
        resp_err  = err_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // job context: owner, size, byte countdown, wait timer, error flag and held result
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      owner         <= 1'b0;
      last          <= 1'b1;
      size_q        <= 32'd0;
      remaining     <= 32'd0;
      wait_cnt      <= 32'd0;
      err_q         <= 1'b0;
      resp_checksum <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            owner     <= pick[1];
            size_q    <= pick_size;
            remaining <= pick_size;
            wait_cnt  <= 32'd0;
            err_q     <= (pick_size == 32'd0);
            if (pick_size == 32'd0) begin
              resp_checksum <= ADLER_INIT;
            end
          end
        end
        ST_STREAM: begin
          if (own_valid) begin
            remaining <= remaining - 32'd1;
          end else begin
            err_q         <= 1'b1;
            resp_checksum <= ADLER_INIT;
          end
        end
        ST_WAIT: begin
          if (eng_checksum_valid) begin
            err_q         <= 1'b0;
            resp_checksum <= eng_checksum;
          end else if (wait_expired) begin
            err_q         <= 1'b1;
            resp_checksum <= ADLER_INIT;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        ST_RESP: begin
          last <= owner;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adler32_sched.sv
// Directed bench for adler32_sched with a requester agent, an engine stub and a job-level model.
module tb_adler32_sched;
  import adler32_pkg::*;

  localparam int WMAX = 8;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [63:0] req_size;
  logic [15:0] req_data;
  logic [1:0]  req_data_valid;
  logic [1:0]  gnt;
  logic [1:0]  data_ready;
  logic [1:0]  done;
  logic        resp_err;
  logic [31:0] resp_checksum;
  logic        eng_size_valid;
  logic [31:0] eng_size;
  logic        eng_data_start;
  logic [7:0]  eng_data;
  logic        eng_checksum_valid;
  logic [31:0] eng_checksum;

  always #5 clock = ~clock;

  adler32_sched #(.WAIT_MAX(WMAX)) dut (
    .clock              (clock),
    .rst_n              (rst_n),
    .req                (req),
    .req_size           (req_size),
    .req_data           (req_data),
    .req_data_valid     (req_data_valid),
    .gnt                (gnt),
    .data_ready         (data_ready),
    .done               (done),
    .resp_err           (resp_err),
    .resp_checksum      (resp_checksum),
    .eng_size_valid     (eng_size_valid),
    .eng_size           (eng_size),
    .eng_data_start     (eng_data_start),
    .eng_data           (eng_data),
    .eng_checksum_valid (eng_checksum_valid),
    .eng_checksum       (eng_checksum)
  );

  // ---------------- requester agent ----------------
  int          issued[2]    = '{0, 0};
  int          completed[2] = '{0, 0};
  int          idx[2]       = '{0, 0};
  int          drop_at[2]   = '{-1, -1};
  logic [7:0]  bytes[2][16];
  logic [31:0] sizes[2]     = '{32'd0, 32'd0};

  assign req[0]            = (issued[0] != completed[0]);
  assign req[1]            = (issued[1] != completed[1]);
  assign req_data_valid[0] = req[0] && (idx[0] != drop_at[0]);
  assign req_data_valid[1] = req[1] && (idx[1] != drop_at[1]);
  assign req_data[7:0]     = bytes[0][idx[0] & 15];
  assign req_data[15:8]    = bytes[1][idx[1] & 15];
  assign req_size[31:0]    = sizes[0];
  assign req_size[63:32]   = sizes[1];

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        completed[i] <= issued[i];
        idx[i]       <= 0;
      end else if (done[i]) begin
        completed[i] <= completed[i] + 1;
        idx[i]       <= 0;
      end else if (data_ready[i] && req_data_valid[i]) begin
        idx[i] <= idx[i] + 1;
      end
    end
  end

  // ---------------- engine stub ----------------
  int          eng_lat   = 2;
  bit          eng_never = 1'b0;
  int          e_a, e_b, e_cnt, e_dly;
  logic [31:0] e_size;
  bit          e_pend;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      eng_checksum_valid <= 1'b0;
      eng_checksum       <= 32'd0;
      e_a <= 1; e_b <= 0; e_cnt <= 0; e_dly <= 0; e_pend <= 1'b0; e_size <= 32'd0;
    end else begin
      eng_checksum_valid <= 1'b0;
      if (eng_size_valid) e_size <= eng_size;
      if (eng_data_start) begin
        e_a <= 1; e_b <= 0; e_cnt <= int'(e_size); e_pend <= 1'b0;
      end else if (e_cnt != 0) begin
        e_a   <= (e_a + int'(eng_data)) % 65521;
        e_b   <= (e_b + (e_a + int'(eng_data)) % 65521) % 65521;
        e_cnt <= e_cnt - 1;
        if (e_cnt == 1) begin
          e_pend <= 1'b1;
          e_dly  <= eng_lat;
        end
      end else if (e_pend) begin
        if (e_dly == 0) begin
          e_pend <= 1'b0;
          if (!eng_never) begin
            eng_checksum_valid <= 1'b1;
            eng_checksum       <= {e_b[15:0], e_a[15:0]};
          end
        end else begin
          e_dly <= e_dly - 1;
        end
      end
    end
  end

  // ---------------- model and scoreboard ----------------
  typedef struct {
    int          owner;
    logic [31:0] size;
    logic [31:0] cks;
    logic        err;
    bit          chk_cks;
    int          nready;
    int          neng;
    int          lat;
  } job_t;

  job_t exp_q[$];
  job_t e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  bit   in_job = 1'b0;
  int   g_cyc, nrdy, nld, nst;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] adler_of(input int r, input int n);
    int unsigned a = 1;
    int unsigned b = 0;
    for (int i = 0; i < n; i++) begin
      a = (a + bytes[r][i]) % ADLER_MOD;
      b = (b + a) % ADLER_MOD;
    end
    return {b[15:0], a[15:0]};
  endfunction

  task automatic load(input int r, input string s);
    for (int i = 0; i < s.len(); i++) bytes[r][i] = s[i];
    sizes[r] = 32'(s.len());
  endtask

  // what a job must produce, from the rules alone
  task automatic expect_job(input int r);
    job_t j;
    int   n = int'(sizes[r]);
    j.owner = r; j.size = sizes[r]; j.chk_cks = 1'b1; j.neng = 1;
    if (n == 0) begin
      j.err = 1'b1; j.cks = ADLER_INIT; j.nready = 0; j.neng = 0; j.lat = 0;
    end else if (drop_at[r] >= 0 && drop_at[r] < n) begin
      j.err = 1'b1; j.cks = ADLER_INIT; j.chk_cks = 1'b0;
      j.nready = drop_at[r] + 1; j.lat = 2 + drop_at[r] + 1;
    end else if (eng_never) begin
      j.err = 1'b1; j.cks = ADLER_INIT; j.nready = n; j.lat = 2 + n + WMAX;
    end else begin
      j.err = 1'b0; j.cks = adler_of(r, n); j.nready = n; j.lat = 2 + n + (eng_lat + 1) + 1;
    end
    exp_q.push_back(j);
  endtask

  // per-cycle comparison against the expected job sequence
  always @(negedge clock) begin
    if (!rst_n) begin
      exp_q.delete();
      in_job = 1'b0;
    end else begin
      if (gnt != 2'b00 && !in_job) begin
        in_job = 1'b1; g_cyc = cyc; nrdy = 0; nld = 0; nst = 0;
      end
      if (in_job) begin
        if (data_ready != 2'b00) nrdy++;
        if (eng_data_start) nst++;
        if (eng_size_valid) begin
          nld++;
          if (exp_q.size() > 0) chk("eng_size", eng_size, exp_q[0].size);
        end
        if (exp_q.size() > 0) chk("gnt_owner", 32'(gnt), 32'(1 << exp_q[0].owner));
      end
      if ((data_ready & req_data_valid) != 2'b00)
        chk("eng_data", 32'(eng_data), 32'(bytes[data_ready[1]][idx[data_ready[1]] & 15]));
      else
        chk("eng_data_zero", 32'(eng_data), 32'd0);
      if (done != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_owner", 32'(done), 32'(1 << e.owner));
          chk("resp_err", 32'(resp_err), 32'(e.err));
          if (e.chk_cks) chk("resp_checksum", resp_checksum, e.cks);
          chk("ready_cycles", 32'(nrdy), 32'(e.nready));
          chk("eng_size_valid_cnt", 32'(nld), 32'(e.neng));
          chk("eng_data_start_cnt", 32'(nst), 32'(e.neng));
          chk("latency", 32'(cyc - g_cyc), 32'(e.lat));
        end
        in_job = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_jobs(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (issued[0] == completed[0] && issued[1] == completed[1]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL job_timeout: jobs still pending after %0d cycles, expected none", budget);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_data_ready"}, 32'(data_ready), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_resp_checksum"}, resp_checksum, 32'd0);
    chk({tag, "_eng_size_valid"}, 32'(eng_size_valid), 32'd0);
    chk({tag, "_eng_size"}, eng_size, 32'd0);
    chk({tag, "_eng_data_start"}, 32'(eng_data_start), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 chk_all_zero("reset");

    // pin the reference model with hand-computed literals
    load(0, "Wikipedia");
    chk("model_wikipedia", adler_of(0, 9), 32'h11E6_0398);
    load(1, "a");
    chk("model_a", adler_of(1, 1), 32'h0062_0062);

    @(negedge clock) rst_n = 1'b1;

    // single job, "Wikipedia"
    load(0, "Wikipedia");
    expect_job(0);
    issued[0]++;
    wait_jobs(200);

    // simultaneous requests straight after reset: requester 0 first
    @(negedge clock) rst_n = 1'b0;
    @(negedge clock) rst_n = 1'b1;
    load(0, "a");
    load(1, "a");
    expect_job(0);
    expect_job(1);
    issued[0]++;
    issued[1]++;
    wait_jobs(200);

    // zero-size job
    sizes[1] = 32'd0;
    expect_job(1);
    issued[1]++;
    wait_jobs(20);

    // starved stream on the 3rd byte, then a clean job
    load(0, "hello");
    drop_at[0] = 2;
    expect_job(0);
    issued[0]++;
    wait_jobs(100);
    drop_at[0] = -1;
    load(0, "abcd");
    expect_job(0);
    issued[0]++;
    wait_jobs(100);

    // engine never answers: timeout
    eng_never = 1'b1;
    load(1, "ab");
    expect_job(1);
    issued[1]++;
    wait_jobs(100);
    eng_never = 1'b0;

    // reset in the middle of streaming: job discarded, outputs cleared at once
    load(0, "Wikipedia");
    issued[0]++;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      if (idx[0] == 3) break;
    end
    chk("midstream_reached", 32'(idx[0]), 32'd3);
    rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    load(1, "xyz");
    expect_job(1);
    issued[1]++;
    wait_jobs(100);

    chk("all_jobs_done", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
